lbp_hist: RTL
=============

# lbp_hist

Downstream consumer of the LBP engine's output stream. Snoops `lbp_valid`/`lbp_addr`/`lbp_data` alongside the LBP result memory and builds a 256-bin histogram of LBP codes over one 128x128 frame. After the engine asserts `finish`, the block streams the 256 bin counts out over a valid/ready handshake for the feature-vector stage.

## Interface
- `CNT_W`, 15: bin counter width; holds 16384 pixels without overflow.
- `IMG_W`, 128: image width/height in pixels; `lbp_addr = row*IMG_W + col`.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `lbp_valid` in 1: LBP output pixel valid this cycle.
- `lbp_addr` in 14: pixel address of `lbp_data`.
- `lbp_data` in 8: LBP code, used as the bin index.
- `finish` in 1: LBP engine done; level, sampled at posedge.
- `hist_valid` out 1: `hist_bin`/`hist_count` valid.
- `hist_ready` in 1: downstream accepts the current bin.
- `hist_bin` out 8: bin index being presented.
- `hist_count` out CNT_W: count for `hist_bin`.
- `hist_done` out 1: all 256 bins accepted; sticky until reset.
- `hist_busy` out 1: high in CLEAR; upstream must not issue pixels.
- `hist_err` out 1: sticky; set when `lbp_valid` arrives outside ACCUM.

## Operation
- FSM states: CLEAR, ACCUM, DRAIN, OUT, DONE.
- CLEAR is entered on reset release. It writes 0 to bins 0..255, one bin per cycle (256 cycles), then moves to ACCUM.
- ACCUM runs a two-stage read-modify-write per accepted pixel.
  - S0: read RAM at `lbp_data`, register the bin.
  - S1: write (read data + 1) back to the same bin.
- Back-to-back pixels are accepted every cycle.
- RAM returns old data on read-during-write, so the block keeps a forwarding register (last written bin and value).
  - If the S1 bin equals the last written bin, the block uses the forwarded value instead of RAM data.
- Counts saturate at 2^CNT_W-1. Saturation is unreachable for one frame but is still required.
- `finish` high in ACCUM moves the FSM to DRAIN. A pixel valid in the same cycle as `finish` is still counted.
- DRAIN waits 2 cycles for the pipeline to empty, then moves to OUT.
- OUT presents bin 0 upward, one bin at a time.
  - `hist_bin`/`hist_count` stay stable while `hist_valid && !hist_ready`.
  - The bin advances on `hist_valid && hist_ready`.
  - Acceptance of bin 255 moves the FSM to DONE.
- DONE holds `hist_done`=1 and `hist_valid`=0 until reset.
- `lbp_valid` in CLEAR, DRAIN, OUT or DONE is ignored (not counted) and sets `hist_err`.
- Reset asserted at any time, including mid-ACCUM or mid-OUT, aborts immediately. On release the FSM restarts at CLEAR and all counts are lost.

## Timing
- Reset values:
  - `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `hist_done`=0, `hist_err`=0.
  - `hist_busy`=1, because CLEAR follows immediately.
- `hist_busy` falls 256 cycles after reset release.
- Pixel-to-RAM-commit latency is 2 cycles.
- `finish` sampled at edge t gives first `hist_valid`=1 at edge t+3.
- OUT reads are prefetched. With `hist_ready` held high, one bin is delivered per cycle with no bubbles, and the stream finishes 256 cycles after the first `hist_valid`.
- `hist_count` is registered (no combinational path from RAM to output).

## Configuration
- `LBP_HIST_BORDER_EXCL_EN`
  - Defined: pixels with row or col equal to 0 or IMG_W-1 are not counted, and do not set `hist_err`. The sum of all bins is 15876.
  - Undefined: every valid pixel is counted. The sum of all bins is 16384.

## Structure
- Package `lbp_hist_pkg`:
  - FSM state enum.
  - `N_BINS`=256.
  - Default `CNT_W`/`IMG_W`.
  - Drain depth constant (2).
- Sub-module `hist_ram`: 256 x CNT_W single-port-write/single-port-read synchronous RAM, 1-cycle read latency, old-data-on-collision.
- The FSM, forwarding and border decode live in the top.

## Test plan
- Reset, then hold 300 cycles, then assert `finish` with no pixels -> `hist_busy` low at cycle 256; 256 bins streamed, all `hist_count`=0; `hist_done`=1.
- Ten back-to-back pixels with code 0x5A at interior addresses -> bin 0x5A=10, all other bins 0. Exercises forwarding.
- Alternating codes 0x01/0x02/0x01 every cycle, 9 pixels -> bin 1=5, bin 2=4.
- Full frame: every pixel code = col[7:0] -> with macro, bins 1..126 = 126 each, bins 0 and 127 = 0; without macro, bins 0..127 = 128 each.
- Random `hist_ready` stalls during OUT -> output held stable during stalls; every bin delivered exactly once, in order 0..255.
- Reset mid-ACCUM after 50 pixels, then re-run a 3-pixel frame -> only the 3 pixels are counted. Also, `lbp_valid` during CLEAR sets `hist_err`=1 and the pixel is not counted.

Source files
------------

// File: rtl/lbp_hist_pkg.sv
// lbp_hist_pkg: shared constants and FSM state type for the LBP code histogram.
package lbp_hist_pkg;
    localparam int N_BINS    = 256;
    localparam int CNT_W_DEF = 15;
    localparam int IMG_W_DEF = 128;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/lbp_hist_ram.sv
// hist_ram: 256 x CNT_W bin storage, 1-cycle registered read, returns old data on read-during-write.
module hist_ram #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [7:0]       waddr_i,
    input  logic [CNT_W-1:0] wdata_i,
    input  logic [7:0]       raddr_i,
    output logic [CNT_W-1:0] rdata_o
);
    logic [CNT_W-1:0] mem_q [256];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes over one frame, streamed out over valid/ready.
// Define LBP_HIST_BORDER_EXCL_EN to drop pixels on the frame border.
module lbp_hist
    import lbp_hist_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int IMG_W = IMG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic             hist_busy,
    output logic             hist_err
);
    localparam int CW = $clog2(IMG_W);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d, nxt_q, nxt_d, bin_q, bin_d, s1_bin_q, fwd_bin_q;
    logic [7:0]       waddr, raddr;
    logic             s1_v_q, fwd_v_q, pend_q, pend_d, valid_q, valid_d, err_q;
    logic [CNT_W-1:0] count_q, count_d, fwd_cnt_q, rdata, base, inc, wdata;
    logic [CW-1:0]    row, col;
    logic             edge_px, pix, acc, load, we;

    assign col     = lbp_addr[CW-1:0];
    assign row     = lbp_addr[2*CW-1:CW];
    assign edge_px = col == '0 || row == '0 || col == CW'(IMG_W - 1) || row == CW'(IMG_W - 1);
`ifdef LBP_HIST_BORDER_EXCL_EN
    assign pix = lbp_valid && !edge_px;
`else
    logic unused_edge;
    assign unused_edge = edge_px;
    assign pix = lbp_valid;
`endif
    assign acc  = pix && state_q == ST_ACCUM;
    assign load = !valid_q || hist_ready;

    // RAM read lags the previous write by one edge, so the last write is forwarded
    assign base  = (fwd_v_q && fwd_bin_q == s1_bin_q) ? fwd_cnt_q : rdata;
    assign inc   = &base ? base : base + 1'b1;
    assign we    = state_q == ST_CLEAR || s1_v_q;
    assign waddr = state_q == ST_CLEAR ? cnt_q : s1_bin_q;
    assign wdata = state_q == ST_CLEAR ? '0 : inc;
    // OUT prefetches the bin that will load next; DRAIN primes bin 0
    assign raddr = state_q == ST_OUT   ? (load ? nxt_q + 8'd1 : nxt_q) :
                   state_q == ST_ACCUM ? lbp_data : 8'd0;

    hist_ram #(.CNT_W(CNT_W)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nxt_d   = nxt_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        bin_d   = bin_q;
        count_d = count_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(N_BINS - 1)) state_d = ST_ACCUM;
            end
            ST_ACCUM: if (finish) state_d = ST_DRAIN;
            ST_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(DRAIN_CYC - 1)) begin
                    cnt_d   = '0;
                    nxt_d   = '0;
                    pend_d  = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (valid_q && hist_ready && bin_q == 8'(N_BINS - 1)) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end else if (load && pend_q) begin
                    valid_d = 1'b1;
                    bin_d   = nxt_q;
                    count_d = rdata;
                    nxt_d   = nxt_q + 8'd1;
                    pend_d  = nxt_q != 8'(N_BINS - 1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            nxt_q     <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            bin_q     <= '0;
            count_q   <= '0;
            s1_v_q    <= 1'b0;
            s1_bin_q  <= '0;
            fwd_v_q   <= 1'b0;
            fwd_bin_q <= '0;
            fwd_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nxt_q    <= nxt_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            bin_q    <= bin_d;
            count_q  <= count_d;
            s1_v_q   <= acc;
            s1_bin_q <= lbp_data;
            err_q    <= err_q || (pix && state_q != ST_ACCUM);
            if (s1_v_q) begin
                fwd_v_q   <= 1'b1;
                fwd_bin_q <= s1_bin_q;
                fwd_cnt_q <= inc;
            end
        end
    end

    assign hist_valid = valid_q;
    assign hist_bin   = bin_q;
    assign hist_count = count_q;
    assign hist_done  = state_q == ST_DONE;
    assign hist_busy  = state_q == ST_CLEAR;
    assign hist_err   = err_q;
endmodule
